// File: rtl/iic_slave_regs.sv
// I2C responder with an 8-bit register pointer.
// Writes go to an external register bank; reads stream from it with auto-increment.
module iic_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         FILTER_LEN = 3
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       IICSCL,
    inout  wire        IICSDA,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, IGNORE, ADDR_ACK, REG, REG_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t state, stateNext;

    logic [1:0]    syncA, syncB, filt;
    logic [CW-1:0] fltCnt [2];
    logic          sclF, sdaF, sclPrev, sdaPrev;
    logic          sclRise, sclFall, startCond, stopCond;
    logic [3:0]    bitCnt;
    logic [7:0]    rxShift, txShift, rxByte;
    logic          rw, sdaOe, loadTx, addrMatch;

    // Bit 1 carries SCL, bit 0 carries SDA through sync and filter
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            syncA     <= 2'b11;
            syncB     <= 2'b11;
            filt      <= 2'b11;
            fltCnt[0] <= '0;
            fltCnt[1] <= '0;
        end else begin
            syncA <= {IICSCL, IICSDA};
            syncB <= syncA;
            for (int i = 0; i < 2; i++) begin
                if (syncB[i] == filt[i]) begin
                    fltCnt[i] <= '0;
                end else if (fltCnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i]   <= syncB[i];
                    fltCnt[i] <= '0;
                end else begin
                    fltCnt[i] <= fltCnt[i] + 1'b1;
                end
            end
        end
    end

    assign sclF = filt[1];
    assign sdaF = filt[0];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclPrev <= sclF;
            sdaPrev <= sdaF;
        end
    end

    assign sclRise   = sclF & ~sclPrev;
    assign sclFall   = ~sclF & sclPrev;
    assign startCond = sclF & sclPrev & sdaPrev & ~sdaF;
    assign stopCond  = sclF & sclPrev & ~sdaPrev & sdaF;
    assign rxByte    = {rxShift[6:0], sdaF};
    assign addrMatch = (rxByte[7:1] == SLAVE_ADDR);
    assign busy      = (state != IDLE);
    assign IICSDA    = sdaOe ? 1'b0 : 1'bz;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (startCond) begin
            stateNext = ADDR;
        end else if (stopCond) begin
            stateNext = IDLE;
        end else begin
            case (state)
                ADDR:
                    if (sclRise && bitCnt == 4'd7)
                        stateNext = addrMatch ? ADDR_ACK : IGNORE;
                ADDR_ACK:
                    if (sclFall && bitCnt == 4'd9)
                        stateNext = rw ? RDATA : REG;
                REG:
                    if (sclRise && bitCnt == 4'd7) stateNext = REG_ACK;
                REG_ACK:
                    if (sclFall && bitCnt == 4'd9) stateNext = WDATA;
                WDATA:
                    if (sclRise && bitCnt == 4'd7) stateNext = WDATA_ACK;
                WDATA_ACK:
                    if (sclFall && bitCnt == 4'd9) stateNext = WDATA;
                RDATA:
                    if (sclFall && bitCnt == 4'd8) stateNext = RDATA_ACK;
                RDATA_ACK:
                    if (sclRise && sdaF)                stateNext = IGNORE;
                    else if (sclFall && bitCnt == 4'd9) stateNext = RDATA;
                default: stateNext = state;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            bitCnt    <= '0;
            rxShift   <= '0;
            txShift   <= '0;
            rw        <= 1'b0;
            sdaOe     <= 1'b0;
            loadTx    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            loadTx <= reg_re;
            if (loadTx) txShift <= reg_rdata;
            if (startCond || stopCond) begin
                bitCnt <= '0;
                sdaOe  <= 1'b0;
            end else begin
                case (state)
                    ADDR, REG, WDATA: begin
                        if (sclRise) begin
                            rxShift <= rxByte;
                            bitCnt  <= bitCnt + 4'd1;
                            if (bitCnt == 4'd7) begin
                                if (state == ADDR) rw <= sdaF;
                                if (state == REG) reg_addr <= rxByte;
                                if (state == WDATA) begin
                                    reg_wdata <= rxByte;
                                    reg_we    <= 1'b1;
                                end
                            end
                        end
                    end
                    ADDR_ACK, REG_ACK, WDATA_ACK: begin
                        if (sclRise) begin
                            bitCnt <= bitCnt + 4'd1;
                            if (state == ADDR_ACK && rw && bitCnt == 4'd8)
                                reg_re <= 1'b1;
                        end
                        if (sclFall && bitCnt == 4'd8) sdaOe <= 1'b1;
                        if (sclFall && bitCnt == 4'd9) begin
                            bitCnt <= '0;
                            sdaOe  <= 1'b0;
                            if (state == WDATA_ACK) reg_addr <= reg_addr + 8'd1;
                            if (state == ADDR_ACK && rw) begin
                                sdaOe   <= ~txShift[7];
                                txShift <= {txShift[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA: begin
                        if (sclRise) bitCnt <= bitCnt + 4'd1;
                        if (sclFall) begin
                            if (bitCnt == 4'd8) begin
                                sdaOe <= 1'b0;
                            end else begin
                                sdaOe   <= ~txShift[7];
                                txShift <= {txShift[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (sclRise) begin
                            bitCnt <= 4'd9;
                            if (!sdaF) begin
                                reg_addr <= reg_addr + 8'd1;
                                reg_re   <= 1'b1;
                            end
                        end
                        if (sclFall && bitCnt == 4'd9) begin
                            bitCnt  <= '0;
                            sdaOe   <= ~txShift[7];
                            txShift <= {txShift[6:0], 1'b0};
                        end
                    end
                    default: sdaOe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_slave_regs.sv
// Directed bench for iic_slave_regs: bus-master tasks, a register bank model
// returning addr+0x40, and table-driven write bursts plus corner sequences.
module tb_iic_slave_regs;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       IICSCL  = 1'b1;
    logic       mSdaLow = 1'b0;
    wire        IICSDA;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;

    int passCnt  = 0;
    int totalCnt = 0;

    logic [7:0] weAddrQ[$];
    logic [7:0] weDataQ[$];
    logic [7:0] reAddrQ[$];
    logic       slaveLow = 1'b0;
    logic       busySeen = 1'b0;
    logic       bothSeen = 1'b0;
    logic       clrMon   = 1'b0;

    assign IICSDA = mSdaLow ? 1'b0 : 1'bz;
    pullup (IICSDA);
    assign reg_rdata = reg_addr + 8'h40;

    always #5 sys_clk = ~sys_clk;

    iic_slave_regs #(.SLAVE_ADDR(7'h3C), .FILTER_LEN(3)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .IICSCL    (IICSCL),
        .IICSDA    (IICSDA),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always @(negedge sys_clk) begin
        if (clrMon) begin
            weAddrQ.delete();
            weDataQ.delete();
            reAddrQ.delete();
            slaveLow = 1'b0;
            busySeen = 1'b0;
        end else begin
            if (reg_we) begin
                weAddrQ.push_back(reg_addr);
                weDataQ.push_back(reg_wdata);
            end
            if (reg_re) reAddrQ.push_back(reg_addr);
            if (reg_we && reg_re) bothSeen = 1'b1;
            if (IICSDA === 1'b0 && !mSdaLow) slaveLow = 1'b1;
            if (busy) busySeen = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endtask

    function automatic logic [7:0] qGet(input logic [7:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 8'hxx;
    endfunction

    task automatic waitN(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic clearMon();
        @(posedge sys_clk);
        clrMon = 1'b1;
        @(posedge sys_clk);
        clrMon = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic bitOut(input logic b, output logic s);
        mSdaLow = ~b;
        waitN(10);
        IICSCL = 1'b1;
        waitN(10);
        s = IICSDA;
        waitN(10);
        IICSCL = 1'b0;
        waitN(10);
    endtask

    task automatic startC();
        mSdaLow = 1'b0;
        waitN(10);
        IICSCL = 1'b1;
        waitN(20);
        mSdaLow = 1'b1;
        waitN(20);
        IICSCL = 1'b0;
        waitN(10);
    endtask

    task automatic stopC();
        mSdaLow = 1'b1;
        waitN(10);
        IICSCL = 1'b1;
        waitN(20);
        mSdaLow = 1'b0;
        waitN(20);
    endtask

    task automatic wrByte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bitOut(b[i], s);
        bitOut(1'b1, s);
        ack = ~s;
    endtask

    task automatic rdByte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bitOut(1'b1, s);
            d[i] = s;
        end
        bitOut(~ack, s);
    endtask

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] fin;
    } wrVec_t;

    wrVec_t vec [3];

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d0, d1;

        vec[0] = '{8'h10, 8'hA5, 8'h5A, 8'h10, 8'h11, 8'h12};
        vec[1] = '{8'hFF, 8'h11, 8'h22, 8'hFF, 8'h00, 8'h01};
        vec[2] = '{8'h7F, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h81};

        waitN(5);
        chk("rst reg_addr", reg_addr, 8'h00);
        chk("rst reg_wdata", reg_wdata, 8'h00);
        chk("rst reg_we", reg_we, 1'b0);
        chk("rst reg_re", reg_re, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst sda", IICSDA, 1'b1);
        rst_n = 1'b1;
        waitN(10);

        for (int v = 0; v < 3; v++) begin
            clearMon();
            startC();
            wrByte(8'h78, ack);
            chk("wr dev ack", ack, 1'b1);
            wrByte(vec[v].ptr, ack);
            chk("wr ptr ack", ack, 1'b1);
            wrByte(vec[v].d0, ack);
            chk("wr d0 ack", ack, 1'b1);
            wrByte(vec[v].d1, ack);
            chk("wr d1 ack", ack, 1'b1);
            stopC();
            waitN(10);
            chk("wr we count", weAddrQ.size(), 2);
            chk("wr we addr0", qGet(weAddrQ, 0), vec[v].a0);
            chk("wr we data0", qGet(weDataQ, 0), vec[v].d0);
            chk("wr we addr1", qGet(weAddrQ, 1), vec[v].a1);
            chk("wr we data1", qGet(weDataQ, 1), vec[v].d1);
            chk("wr final addr", reg_addr, vec[v].fin);
            chk("wr busy idle", busy, 1'b0);
            chk("wr no re", reAddrQ.size(), 0);
        end

        clearMon();
        startC();
        wrByte(8'h78, ack);
        wrByte(8'h20, ack);
        startC();
        wrByte(8'h79, ack);
        chk("rd dev ack", ack, 1'b1);
        rdByte(1'b1, d0);
        rdByte(1'b0, d1);
        stopC();
        waitN(10);
        chk("rd byte0", d0, 8'h60);
        chk("rd byte1", d1, 8'h61);
        chk("rd re count", reAddrQ.size(), 2);
        chk("rd re addr0", qGet(reAddrQ, 0), 8'h20);
        chk("rd re addr1", qGet(reAddrQ, 1), 8'h21);
        chk("rd final addr", reg_addr, 8'h21);
        chk("rd no we", weAddrQ.size(), 0);
        chk("rd busy idle", busy, 1'b0);

        clearMon();
        startC();
        chk("mis busy start", busy, 1'b1);
        wrByte(8'h7A, ack);
        chk("mis dev nack", ack, 1'b0);
        wrByte(8'h10, ack);
        wrByte(8'hFF, ack);
        chk("mis busy mid", busy, 1'b1);
        stopC();
        waitN(10);
        chk("mis busy stop", busy, 1'b0);
        chk("mis sda low", slaveLow, 1'b0);
        chk("mis we", weAddrQ.size(), 0);
        chk("mis re", reAddrQ.size(), 0);

        clearMon();
        mSdaLow = 1'b1;
        waitN(2);
        mSdaLow = 1'b0;
        waitN(20);
        chk("glitch busy", busySeen, 1'b0);

        clearMon();
        startC();
        wrByte(8'h78, ack);
        wrByte(8'h30, ack);
        bitOut(1'b1, s);
        bitOut(1'b0, s);
        bitOut(1'b1, s);
        bitOut(1'b0, s);
        stopC();
        waitN(10);
        chk("abort busy", busy, 1'b0);
        chk("abort we", weAddrQ.size(), 0);
        chk("abort sda", IICSDA, 1'b1);
        chk("abort addr", reg_addr, 8'h30);

        startC();
        wrByte(8'h78, ack);
        wrByte(8'h50, ack);
        startC();
        wrByte(8'h79, ack);
        bitOut(1'b1, s);
        chk("rr bit7", s, 1'b1);
        chk("rr drive 0", IICSDA, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rr sda rel", IICSDA, 1'b1);
        chk("rr addr", reg_addr, 8'h00);
        chk("rr wdata", reg_wdata, 8'h00);
        chk("rr busy", busy, 1'b0);
        chk("rr we", reg_we, 1'b0);
        chk("rr re", reg_re, 1'b0);
        IICSCL = 1'b1;
        waitN(10);
        rst_n = 1'b1;
        waitN(10);
        clearMon();
        startC();
        wrByte(8'h78, ack);
        chk("post dev ack", ack, 1'b1);
        wrByte(8'h40, ack);
        wrByte(8'h77, ack);
        chk("post data ack", ack, 1'b1);
        stopC();
        waitN(10);
        chk("post we count", weAddrQ.size(), 1);
        chk("post we addr", qGet(weAddrQ, 0), 8'h40);
        chk("post we data", qGet(weDataQ, 0), 8'h77);
        chk("post final addr", reg_addr, 8'h41);
        chk("we re overlap", bothSeen, 1'b0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/iic_slave_regs.md
Name: iic_slave_regs

Overview:
I2C responder (slave) for the on-board two-wire bus. It recognises a 7-bit device address and takes an 8-bit register pointer. It then either writes received bytes to an external register bank or streams register contents back to the initiator, auto-incrementing the pointer. It is used to close the loop with the team's I2C initiator in simulation and on-chip tests, and as a configuration port for FPGA-side registers.

Parameters:
SLAVE_ADDR, 7'h3C, 7-bit device address matched against the first byte after START (bits 7:1).
FILTER_LEN, 3, number of consecutive equal sys_clk samples required before a filtered SCL/SDA level changes.

Ports:
sys_clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
IICSCL  input  1  bus clock from initiator (no clock stretching).
IICSDA  inout  1  bus data, open-drain: driven 0 or released (1'bz), never driven 1.
reg_addr  output  8  current register pointer.
reg_wdata  output  8  byte received for write; valid while reg_we=1.
reg_we  output  1  one-cycle write strobe.
reg_re  output  1  one-cycle read-fetch strobe; reg_rdata is sampled 1 cycle later.
reg_rdata  input  8  register bank read data for reg_addr.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE, reg_addr 8'h00, reg_wdata 8'h00, reg_we 0, reg_re 0, busy 0, SDA released, filters preset to 1.
- Input path: 2-FF synchroniser on SCL and SDA, then a FILTER_LEN stability filter producing scl_f/sda_f. Edges are detected on scl_f against its previous value. sys_clk must be ≥ 20x SCL frequency.
- START (sda_f 1→0 while scl_f=1), from any state incl. mid-byte: go to ADDR, clear bit counter, release SDA. reg_addr is retained, which supports pointer-write + repeated-START read.
- STOP (sda_f 0→1 while scl_f=1), from any state: go to IDLE, release SDA.
- Bits are sampled MSB first on scl_f rising. The slave changes its SDA drive only after scl_f falling.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th rising edge:
    - if bits[7:1]==SLAVE_ADDR, latch rw=bit0 and go to ADDR_ACK;
    - otherwise go to IGNORE.
  - IGNORE: SDA released. Stay until START or STOP.
  - ADDR_ACK: drive SDA=0 from the 8th falling edge to the 9th falling edge.
    - rw=0: go to REG.
    - rw=1: pulse reg_re at the 9th rising edge, latch reg_rdata into the tx shift register the next cycle, then go to RDATA at the 9th falling edge.
  - REG: shift 8 bits, load reg_addr on the 8th rising edge, then REG_ACK (ACK as above) → WDATA.
  - WDATA: shift 8 bits. On the 8th rising edge, set reg_wdata and pulse reg_we for 1 cycle with the current reg_addr. Then WDATA_ACK (ACK driven). At the 9th falling edge, reg_addr += 1 (8'hFF wraps to 8'h00), then back to WDATA.
  - RDATA: after each scl_f falling edge, SDA = tx bit (0 → drive low, 1 → release), MSB first. After the 8th falling edge, release SDA → RDATA_ACK.
  - RDATA_ACK: sample SDA at the 9th rising edge.
    - 0 (ACK): reg_addr += 1 (wrap), pulse reg_re, latch reg_rdata next cycle, go to RDATA at the 9th falling edge.
    - 1 (NACK): go to IGNORE (wait for STOP/START).
- reg_we and reg_re are never asserted in the same cycle and never outside a matched transaction.
- Bytes after a write, a repeated START, or a NACK do not affect pointer semantics except as stated above.
- Reset mid-transfer: immediate return to reset values; SDA released in the same cycle as rst_n falls.

Test Plan:
- Write burst: START, 0x78, 0x10, 0xA5, 0x5A, STOP.
  - Required: ACK on all four bytes.
  - reg_we pulses twice: (addr 0x10, data 0xA5), then (addr 0x11, data 0x5A).
  - Final reg_addr 0x12; busy returns 0 after STOP.
- Pointer + repeated START read: START, 0x78, 0x20, rSTART, 0x79, then read 2 bytes (ACK then NACK), STOP. Bank returns addr+0x40.
  - Required: bytes 0x60, 0x61 on SDA.
  - reg_re pulses at addresses 0x20 and 0x21; reg_addr ends at 0x21.
- Address mismatch: START, 0x7A, 0x10, 0xFF, STOP.
  - Required: SDA never driven low, no reg_we or reg_re.
  - busy high from START to STOP.
- Pointer wrap: write pointer 0xFF, then data 0x11, 0x22.
  - Required: writes land at 0xFF then 0x00; reg_addr ends at 0x01.
- Glitch and abort:
  - A 2-cycle SDA low pulse while SCL is high is ignored (no START).
  - STOP after 4 bits of a data byte gives IDLE, no reg_we, SDA released.
- Reset mid-read: assert rst_n=0 while driving a 0 bit.
  - Required: SDA released immediately, all outputs at reset values.
  - The next full write transaction completes normally.
